sram_bank_arbiter: RTL and testbench
====================================

# sram_bank_arbiter

Shares a single SRAM bank interface between NUM_REQ requesters, for example an AXI SRAM front-end and a DMA or scrub engine. Each cycle the block selects one request with round-robin arbitration. A requester can lock the grant across consecutive beats to keep a burst together. The selected access is registered onto the bank pins, and each read result is routed back to its requester after the fixed macro latency.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, ≥2.
- ADDR_WIDTH, 16: bank word address width.
- DATA_WIDTH, 32: bank data width, multiple of 8.
- READ_LATENCY, 2: cycles from bank_cs_o high to bank_rdata_i valid, ≥1.

Ports (clock and reset first):
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  request valid, one bit per requester.
- req_ready_o  out  NUM_REQ  grant; a handshake is valid & ready.
- req_lock_i  in  NUM_REQ  keep the grant after this beat.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ×ADDR_WIDTH  word address.
- req_be_i  in  NUM_REQ×DATA_WIDTH/8  byte enables for writes.
- req_wdata_i  in  NUM_REQ×DATA_WIDTH  write data.
- rsp_valid_o  out  NUM_REQ  read data valid for requester k.
- rsp_rdata_o  out  DATA_WIDTH  read data, shared by all requesters.
- bank_cs_o  out  1  chip select.
- bank_we_o  out  1  write enable.
- bank_be_o  out  DATA_WIDTH/8  byte enables.
- bank_addr_o  out  ADDR_WIDTH  address.
- bank_wdata_o  out  DATA_WIDTH  write data.
- bank_rdata_i  in  DATA_WIDTH  read data from the macro.

## Operation
- **FSM states:** IDLE and LOCKED; reset state IDLE.
- **IDLE arbitration:**
  - Scan the valid requesters starting at index rr_ptr+1 mod NUM_REQ; the first one found is granted.
  - At most one req_ready_o bit is high, and it goes high only alongside its valid (ready = valid & grant, combinational).
  - On a handshake, rr_ptr takes the granted index.
  - If req_lock_i[g] is high on that handshake, move to LOCKED with owner = g.
- **LOCKED:**
  - Only the owner can be granted; all other ready bits are 0.
  - While the owner's valid is low, the bank stays idle and the state is held.
  - A handshake from the owner with its lock low returns the FSM to IDLE; rr_ptr is set to the owner.
- **Bank drive:**
  - On a handshake, register cs=1, we, be, addr and wdata from the granted requester.
  - With no handshake, cs=0 and we=0; be, addr and wdata hold their last values.
- **Read return:** a READ_LATENCY+1 deep shift register carries {valid, owner index} for each read. When the entry leaves the final stage:
  - rsp_valid_o[owner] is set to 1.
  - rsp_rdata_o = bank_rdata_i, passed through combinationally.
- **Responses cannot be backpressured.** Every requester must accept its data in the cycle rsp_valid_o is high.
- **Writes** produce no response.
- **rr_ptr** is $clog2(NUM_REQ) bits wide and wraps modulo NUM_REQ; NUM_REQ need not be a power of 2.

## Timing
- **Reset values:**
  - req_ready_o = 0 and rsp_valid_o = 0 (all bits).
  - bank_cs_o = 0, bank_we_o = 0, bank_be_o = 0, bank_addr_o = 0, bank_wdata_o = 0.
  - rsp_rdata_o follows bank_rdata_i.
  - State IDLE, rr_ptr = NUM_REQ-1 (so requester 0 wins first), pipeline cleared.
- **Latency:** a handshake in cycle t puts bank_cs_o high in cycle t+1. A read response appears on rsp_valid_o in cycle t+1+READ_LATENCY.
- **Throughput:** one access per cycle, back-to-back, with no bubbles across changes of requester.
- **Simultaneous events:** a read response and a new grant are independent and may occur in the same cycle.
- **Reset mid-operation:** reads in flight are discarded with no spurious rsp_valid_o, and any lock is released.
- **Combinational paths:** req_ready_o depends on req_valid_i. There is no combinational path from req_* to bank_*.

## Structure
- Package sram_arb_pkg holds:
  - arb_state_t, the IDLE/LOCKED enum.
  - rd_tag_t, a packed struct {valid, owner}.
- Sub-module rr_arbiter_fixed: combinational round-robin pick that takes the request vector and the pointer and returns a one-hot grant and the grant index.
- Top level: the FSM, the bank output registers and the tag pipeline.

## Test plan
- **Single read, NUM_REQ=2, READ_LATENCY=2:** requester 0 reads addr 0x0010 at cycle 5.
  - Required: bank_cs_o=1 and bank_addr_o=0x0010 at cycle 6.
  - Required: rsp_valid_o=2'b01 at cycle 8 with rsp_rdata_o equal to the model data.
- **Fairness:** both requesters valid continuously for 8 cycles, no lock.
  - Required: grants alternate 0,1,0,1…, each requester gets 4 grants, and no bank idle cycle occurs.
- **Lock:** requester 1 makes 4 writes with lock high on beats 0–2 and lock low on beat 3, while requester 0 is also valid.
  - Required: requester 0 is not granted until the 4 writes complete; it is granted on the next cycle.
  - Required: bank_we_o=1 for 4 consecutive cycles.
- **Interleaved return:** reads from requesters 0, 1, 0 in consecutive cycles.
  - Required: rsp_valid_o sequence 01, 10, 01 starting 3 cycles after the first handshake.
- **Reset mid-burst:** assert rst_ni low 1 cycle after issuing 2 reads.
  - Required: rsp_valid_o stays 0, bank_cs_o=0, and after release requester 0 is granted first.
- **Write byte enables:** a write with be=4'b0101 and wdata=0xAABBCCDD.
  - Required: bank_be_o=4'b0101, bank_wdata_o=0xAABBCCDD, and no rsp_valid_o is generated.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bank arbiter: FSM state encoding and read-return tag.
package sram_arb_pkg;

  // Owner field is sized for up to 256 requesters; the top checks NUM_REQ against it.
  localparam int unsigned OWNER_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter_fixed.sv
// Combinational round-robin pick: the first requester after ptr_i (wrapping
// modulo NUM_REQ) wins. Works for non-power-of-two NUM_REQ.
module rr_arbiter_fixed #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  // Scan ptr+1 .. ptr+NUM_REQ; the last candidate is the previous winner itself.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    int               cand;
    found       = 1'b0;
    idx         = '0;
    cand        = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = (int'(ptr_i) + i) % int'(NUM_REQ);
      idx  = PTR_W'(cand);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one SRAM bank between NUM_REQ requesters, with
// optional grant locking for bursts and tagged read-data return.
//
// state  | meaning
// IDLE   | round-robin arbitration among all valid requesters
// LOCKED | only owner_q may be granted; released by a beat with lock low
module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_lock_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             bank_cs_o,
  output logic                             bank_we_o,
  output logic [DATA_WIDTH/8-1:0]          bank_be_o,
  output logic [ADDR_WIDTH-1:0]            bank_addr_o,
  output logic [DATA_WIDTH-1:0]            bank_wdata_o,
  input  logic [DATA_WIDTH-1:0]            bank_rdata_i
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = READ_LATENCY + 1;

  if (NUM_REQ < 2 || NUM_REQ > (1 << OWNER_W)) begin : g_bad_num_req
    $error("NUM_REQ out of supported range");
  end

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               hs;

  logic                  sel_we;
  logic [BE_W-1:0]       sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rd_tag_t new_tag;
  rd_tag_t tag_q [DEPTH];

  rr_arbiter_fixed #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // FSM state, lock owner and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state and grant; a grant bit is only ever set for a valid requester.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt      = '0;
    gnt_idx  = arb_idx;
    case (state_q)
      IDLE: begin
        gnt = arb_gnt;
        if (arb_valid) begin
          rr_ptr_d = arb_idx;
          if (req_lock_i[arb_idx]) begin
            state_d = LOCKED;
            owner_d = arb_idx;
          end
        end
      end
      LOCKED: begin
        gnt_idx = owner_q;
        if (req_valid_i[owner_q]) begin
          gnt[owner_q] = 1'b1;
          rr_ptr_d     = owner_q;
          if (!req_lock_i[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs          = |gnt;
  assign req_ready_o = gnt;

  // Route the granted requester's access fields; the grant is one-hot.
  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        sel_we    = req_we_i[i];
        sel_be    = req_be_i[i*BE_W +: BE_W];
        sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Bank pins are registered; be/addr/wdata hold between accesses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_cs_o    <= 1'b0;
      bank_we_o    <= 1'b0;
      bank_be_o    <= '0;
      bank_addr_o  <= '0;
      bank_wdata_o <= '0;
    end else if (hs) begin
      bank_cs_o    <= 1'b1;
      bank_we_o    <= sel_we;
      bank_be_o    <= sel_be;
      bank_addr_o  <= sel_addr;
      bank_wdata_o <= sel_wdata;
    end else begin
      bank_cs_o <= 1'b0;
      bank_we_o <= 1'b0;
    end
  end

  assign new_tag.valid = hs & ~sel_we;
  assign new_tag.owner = OWNER_W'(gnt_idx);

  // Read tags travel alongside the macro latency; stage 0 lines up with bank_cs_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i < int'(DEPTH); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Decode the final-stage tag into the per-requester response strobe.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid_o[i] = tag_q[DEPTH-1].valid && (tag_q[DEPTH-1].owner == OWNER_W'(i));
    end
  end

  assign rsp_rdata_o = bank_rdata_i;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter (NUM_REQ=2, READ_LATENCY=2) with a
// simple delay-line model of the SRAM macro read port.
module tb_sram_bank_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_lock_i;
  logic [1:0]  req_we_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_be_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        bank_cs_o;
  logic        bank_we_o;
  logic [3:0]  bank_be_o;
  logic [15:0] bank_addr_o;
  logic [31:0] bank_wdata_o;
  logic [31:0] bank_rdata_i;

  int checks = 0;
  int errors = 0;

  sram_bank_arbiter #(
    .NUM_REQ      (2),
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (32),
    .READ_LATENCY (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_lock_i   (req_lock_i),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_be_i     (req_be_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .bank_cs_o    (bank_cs_o),
    .bank_we_o    (bank_we_o),
    .bank_be_o    (bank_be_o),
    .bank_addr_o  (bank_addr_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_rdata_i (bank_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Macro model: read data = {addr ^ 16'h5A5A, addr}, two cycles after cs.
  function automatic logic [31:0] model_data(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  logic [31:0] dl0, dl1;
  assign bank_rdata_i = dl1;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl0 <= 32'h1234_5678;
      dl1 <= 32'h1234_5678;
    end else begin
      dl0 <= (bank_cs_o && !bank_we_o) ? model_data(bank_addr_o) : 32'h0;
      dl1 <= dl0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic we, input logic lk,
                       input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
    req_valid_i[k]         = v;
    req_we_i[k]            = we;
    req_lock_i[k]          = lk;
    req_addr_i[k*16 +: 16] = a;
    req_be_i[k*4 +: 4]     = be;
    req_wdata_i[k*32 +: 32] = wd;
  endtask

  task automatic idle_all();
    req_valid_i = '0;
    req_lock_i  = '0;
    req_we_i    = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  exp_rdy [6] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
  logic [1:0]  exp_rsp [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
  logic [31:0] exp_dat [6] = '{32'h0, 32'h0, 32'h5A1A_0040, 32'h5A1B_0041, 32'h5A18_0042, 32'h0};

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0, g1;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_lock_i  = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_be_i    = '0;
    req_wdata_i = '0;
    step();
    step();

    // Reset values.
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_rsp",   rsp_valid_o, 2'b00);
    chk("rst_cs",    bank_cs_o, 1'b0);
    chk("rst_we",    bank_we_o, 1'b0);
    chk("rst_be",    bank_be_o, 4'h0);
    chk("rst_addr",  bank_addr_o, 16'h0);
    chk("rst_wdata", bank_wdata_o, 32'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h1234_5678);
    rst_ni = 1'b1;
    step();
    step();

    // Single read from requester 0.
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 32'h0);
    #1 chk("t1_ready", req_ready_o, 2'b01);
    step();
    chk("t1_cs",   bank_cs_o, 1'b1);
    chk("t1_we",   bank_we_o, 1'b0);
    chk("t1_addr", bank_addr_o, 16'h0010);
    idle_all();
    step();
    chk("t1_rsp_early", rsp_valid_o, 2'b00);
    step();
    chk("t1_rsp",   rsp_valid_o, 2'b01);
    chk("t1_rdata", rsp_rdata_o, 32'h5A4A_0010);
    step();
    chk("t1_rsp_after", rsp_valid_o, 2'b00);

    // Fairness: both writing for 8 cycles; last winner was 0, so 1 goes first.
    g0 = 0;
    g1 = 0;
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0100, 4'hF, 32'h1111_0000);
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0200, 4'hF, 32'h2222_0000);
    for (int c = 0; c < 8; c++) begin
      #1 chk("fair_ready", req_ready_o, (c % 2 == 0) ? 2'b10 : 2'b01);
      if (req_ready_o[0]) g0++;
      if (req_ready_o[1]) g1++;
      step();
      chk("fair_cs",   bank_cs_o, 1'b1);
      chk("fair_addr", bank_addr_o, (c % 2 == 0) ? 16'h0200 : 16'h0100);
    end
    chk("fair_cnt0", g0, 4);
    chk("fair_cnt1", g1, 4);
    idle_all();

    // Lock: requester 1 four-beat write burst while requester 0 waits.
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0111, 4'hF, 32'h0000_0111);
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, 1'b1, (b < 3), 16'h0300 + 16'(b), 4'hF, 32'hCAFE_0000 + 32'(b));
      #1 chk("lock_ready", req_ready_o, 2'b10);
      step();
      chk("lock_we",   bank_we_o, 1'b1);
      chk("lock_addr", bank_addr_o, 16'h0300 + 16'(b));
    end
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    #1 chk("lock_rel_ready", req_ready_o, 2'b01);
    step();
    chk("lock_rel_addr", bank_addr_o, 16'h0111);
    idle_all();

    // Interleaved reads 0,1,0 with responses overlapping new grants.
    for (int c = 0; c < 6; c++) begin
      idle_all();
      if (c == 0) drive(0, 1'b1, 1'b0, 1'b0, 16'h0040, 4'hF, 32'h0);
      if (c == 1) drive(1, 1'b1, 1'b0, 1'b0, 16'h0041, 4'hF, 32'h0);
      if (c == 2) drive(0, 1'b1, 1'b0, 1'b0, 16'h0042, 4'hF, 32'h0);
      #1 chk("il_ready", req_ready_o, exp_rdy[c]);
      step();
      chk("il_rsp",   rsp_valid_o, exp_rsp[c]);
      chk("il_rdata", rsp_rdata_o, exp_dat[c]);
    end

    // Reset mid-burst: read from 1, then locked read from 0, then reset.
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0051, 4'hF, 32'h0);
    #1 chk("mr_ready1", req_ready_o, 2'b10);
    step();
    idle_all();
    drive(0, 1'b1, 1'b0, 1'b1, 16'h0050, 4'hF, 32'h0);
    #1 chk("mr_ready0", req_ready_o, 2'b01);
    step();
    idle_all();
    rst_ni = 1'b0;
    #1;
    chk("mr_cs",    bank_cs_o, 1'b0);
    chk("mr_rsp",   rsp_valid_o, 2'b00);
    chk("mr_ready", req_ready_o, 2'b00);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("mr_hold_rsp", rsp_valid_o, 2'b00);
      chk("mr_hold_cs",  bank_cs_o, 1'b0);
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mr_post_rsp", rsp_valid_o, 2'b00);
      chk("mr_post_cs",  bank_cs_o, 1'b0);
    end
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0600, 4'hF, 32'h6);
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0601, 4'hF, 32'h7);
    #1 chk("mr_first", req_ready_o, 2'b01);
    step();
    chk("mr_first_addr", bank_addr_o, 16'h0600);
    #1 chk("mr_second", req_ready_o, 2'b10);
    step();
    chk("mr_second_addr", bank_addr_o, 16'h0601);
    idle_all();

    // Write with partial byte enables: no response, fields hold afterwards.
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0077, 4'b0101, 32'hAABB_CCDD);
    #1 chk("be_ready", req_ready_o, 2'b01);
    step();
    chk("be_cs",    bank_cs_o, 1'b1);
    chk("be_we",    bank_we_o, 1'b1);
    chk("be_be",    bank_be_o, 4'b0101);
    chk("be_wdata", bank_wdata_o, 32'hAABB_CCDD);
    chk("be_addr",  bank_addr_o, 16'h0077);
    idle_all();
    step();
    chk("be_idle_cs",    bank_cs_o, 1'b0);
    chk("be_idle_we",    bank_we_o, 1'b0);
    chk("be_hold_be",    bank_be_o, 4'b0101);
    chk("be_hold_wdata", bank_wdata_o, 32'hAABB_CCDD);
    chk("be_hold_addr",  bank_addr_o, 16'h0077);
    for (int c = 0; c < 4; c++) begin
      chk("be_no_rsp", rsp_valid_o, 2'b00);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
